// File: rtl/seqdet_param.sv
// Programmable serial pattern detector with a runtime-loaded pattern and length.
// Supports overlapping and non-overlapping detection plus a saturating match counter.
module seqdet_param #(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned LW     = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               x,
  input  logic               x_valid,
  input  logic [MAX_LEN-1:0] seq,
  input  logic [LW-1:0]      seq_len,
  input  logic               cfg_load,
  input  logic               overlap,
  input  logic               cnt_clr,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               cfg_err
);

  localparam logic [LW-1:0] FillMax = LW'(MAX_LEN);

  logic [MAX_LEN-1:0] hist_q, pat_q;
  logic [LW-1:0]      fill_q, len_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               z_q, err_q;

  logic [MAX_LEN-1:0] hist_nxt, len_mask;
  logic [LW-1:0]      fill_inc;
  logic               match;

  always_comb begin
    hist_nxt = {hist_q[MAX_LEN-2:0], x};
    fill_inc = (fill_q == FillMax) ? fill_q : fill_q + 1'b1;
    len_mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    // Only the low len_q bits of history take part in the comparison.
    match = x_valid && !cfg_load && !err_q && (fill_inc >= len_q) &&
            ((hist_nxt & len_mask) == (pat_q & len_mask));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= '0;
      len_q  <= '0;
      z_q    <= 1'b0;
      cnt_q  <= '0;
      err_q  <= 1'b1;
    end else begin
      z_q <= match;
      if (cfg_load) begin
        pat_q  <= seq;
        len_q  <= seq_len;
        err_q  <= (seq_len == '0) || (seq_len > FillMax);
        hist_q <= '0;
        fill_q <= '0;
      end else if (x_valid) begin
        hist_q <= hist_nxt;
        fill_q <= (match && !overlap) ? '0 : fill_inc;
      end
      if (cnt_clr) begin
        cnt_q <= match ? CNT_W'(1) : '0;
      end else if (match && !(&cnt_q)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign z         = z_q;
  assign match_cnt = cnt_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_seqdet_param.sv
// Directed bench for seqdet_param; a second instance with a 2-bit counter
// shares all inputs to exercise saturation.
module tb_seqdet_param;

  logic        clk = 1'b0;
  logic        rst, x, x_valid, cfg_load, overlap, cnt_clr;
  logic [15:0] seq;
  logic [4:0]  seq_len;
  logic        z, cfg_err, z2, cfg_err2;
  logic [7:0]  match_cnt;
  logic [1:0]  match_cnt2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seqdet_param u_dut (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .seq(seq), .seq_len(seq_len),
    .cfg_load(cfg_load), .overlap(overlap), .cnt_clr(cnt_clr),
    .z(z), .match_cnt(match_cnt), .cfg_err(cfg_err)
  );

  seqdet_param #(.MAX_LEN(16), .CNT_W(2)) u_dut_c2 (
    .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .seq(seq), .seq_len(seq_len),
    .cfg_load(cfg_load), .overlap(overlap), .cnt_clr(cnt_clr),
    .z(z2), .match_cnt(match_cnt2), .cfg_err(cfg_err2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // The strobe cycle also carries a valid bit that must be discarded; seq/seq_len
  // are scrambled afterwards since they only matter during cfg_load.
  task automatic cfg(input logic [15:0] s, input logic [4:0] l);
    seq      = s;
    seq_len  = l;
    cfg_load = 1'b1;
    x_valid  = 1'b1;
    x        = 1'b1;
    tick();
    cfg_load = 1'b0;
    x_valid  = 1'b0;
    seq      = 16'hffff;
    seq_len  = 5'd2;
  endtask

  task automatic send(input logic b, input logic ez, input string tag);
    x       = b;
    x_valid = 1'b1;
    tick();
    x_valid = 1'b0;
    chk(tag, {31'd0, z}, {31'd0, ez});
  endtask

  task automatic send_vec(input logic [15:0] bits, input logic [15:0] zexp, input int n,
                          input string tag);
    for (int i = n - 1; i >= 0; i--) send(bits[i], zexp[i], tag);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk("idle_z", {31'd0, z}, 32'd0);
    end
  endtask

  task automatic clear_cnt();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  initial begin
    rst = 1'b0; x = 1'b0; x_valid = 1'b0; cfg_load = 1'b0; overlap = 1'b0; cnt_clr = 1'b0;
    seq = '0; seq_len = '0;
    tick();
    tick();
    chk("rst_z", {31'd0, z}, 32'd0);
    chk("rst_cnt", {24'd0, match_cnt}, 32'd0);
    chk("rst_err", {31'd0, cfg_err}, 32'd1);
    rst = 1'b1;
    tick();

    // overlapping detection
    overlap = 1'b1;
    cfg(16'b101010, 5'd6);
    chk("ov_err", {31'd0, cfg_err}, 32'd0);
    send_vec(16'b101010101010, 16'h055, 12, "ov_z");
    chk("ov_cnt", {24'd0, match_cnt}, 32'd4);
    chk("ov_cnt2_sat", {30'd0, match_cnt2}, 32'd3);
    clear_cnt();
    chk("clr_cnt", {24'd0, match_cnt}, 32'd0);

    // non-overlapping detection
    overlap = 1'b0;
    cfg(16'b101010, 5'd6);
    send_vec(16'b101010101010, 16'h041, 12, "nov_z");
    chk("nov_cnt", {24'd0, match_cnt}, 32'd2);
    clear_cnt();

    // idle gaps between valid bits
    overlap = 1'b1;
    cfg(16'b110, 5'd3);
    send(1'b1, 1'b0, "gap_z");
    idle(5);
    send(1'b1, 1'b0, "gap_z");
    idle(5);
    send(1'b0, 1'b1, "gap_z");
    chk("gap_cnt", {24'd0, match_cnt}, 32'd1);

    // illegal lengths
    cfg(16'b110, 5'd0);
    chk("len0_err", {31'd0, cfg_err}, 32'd1);
    send_vec(16'b110110, 16'd0, 6, "len0_z");
    chk("len0_cnt", {24'd0, match_cnt}, 32'd1);
    cfg(16'b110, 5'd17);
    chk("len17_err", {31'd0, cfg_err}, 32'd1);
    send_vec(16'b110110, 16'd0, 6, "len17_z");
    chk("len17_cnt", {24'd0, match_cnt}, 32'd1);

    // saturation and clear-with-match
    overlap = 1'b0;
    cfg(16'b110, 5'd3);
    chk("sat_err", {31'd0, cfg_err}, 32'd0);
    clear_cnt();
    send_vec(16'b110110110110110, 16'b001001001001001, 15, "sat_z");
    chk("sat_cnt8", {24'd0, match_cnt}, 32'd5);
    chk("sat_cnt2", {30'd0, match_cnt2}, 32'd3);
    send(1'b1, 1'b0, "clrm_z");
    send(1'b1, 1'b0, "clrm_z");
    cnt_clr = 1'b1;
    send(1'b0, 1'b1, "clrm_z");
    cnt_clr = 1'b0;
    chk("clrm_cnt8", {24'd0, match_cnt}, 32'd1);
    chk("clrm_cnt2", {30'd0, match_cnt2}, 32'd1);
    clear_cnt();
    chk("clr_cnt2", {30'd0, match_cnt2}, 32'd0);

    // reset in the middle of a partial match
    overlap = 1'b1;
    cfg(16'b101010, 5'd6);
    send_vec(16'b10101, 16'd0, 5, "rmid_z");
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("rmid_err", {31'd0, cfg_err}, 32'd1);
    chk("rmid_cnt", {24'd0, match_cnt}, 32'd0);
    cfg(16'b101010, 5'd6);
    send(1'b0, 1'b0, "rmid_6th");
    send_vec(16'b101010, 16'b000001, 6, "rmid_full");
    chk("rmid_cnt2", {24'd0, match_cnt}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seqdet_param.md
SEQDET_PARAM -- requirements
Module: seqdet_param

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 16, giving the maximum pattern length in bits (legal range 2..32).
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the match-counter width in bits.
REQ-003 The block SHALL define derived width LW = clog2(MAX_LEN+1) for the length fields.
REQ-004 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port: rst  input  1  synchronous, active-low reset.
REQ-006 Port: x  input  1  serial data bit.
REQ-007 Port: x_valid  input  1  x is sampled only in cycles where x_valid=1.
REQ-008 Port: seq  input  MAX_LEN  pattern; bit seq_len-1 is the first bit expected, bit 0 the last.
REQ-009 Port: seq_len  input  LW  pattern length in bits.
REQ-010 Port: cfg_load  input  1  one-cycle strobe that latches seq and seq_len.
REQ-011 Port: overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
REQ-012 Port: cnt_clr  input  1  clears the match counter.
REQ-013 Port: z  output  1  one-cycle match pulse.
REQ-014 Port: match_cnt  output  CNT_W  saturating count of matches.
REQ-015 Port: cfg_err  output  1  latched length is illegal.

Function
REQ-016 Internal state SHALL comprise a MAX_LEN-bit history shift register, a fill counter (0..MAX_LEN), the latched pattern and the latched length.
REQ-017 On each cycle with x_valid=1 and cfg_load=0, x SHALL shift into history bit 0 (older bits move toward the MSB) and fill SHALL increment, saturating at MAX_LEN.
REQ-018 A match SHALL be declared in a cycle with x_valid=1 and cfg_load=0 when the updated fill is >= the latched length, the low length bits of the updated history equal the low length bits of the latched pattern, and cfg_err=0.
REQ-019 z SHALL be registered: it is 1 in the cycle after the match cycle and 0 otherwise, giving a latency of one clock from the completing bit.
REQ-020 On a match with overlap=1, fill SHALL keep its incremented value; on a match with overlap=0, fill SHALL be cleared to 0 so the next match needs the full length of fresh bits.
REQ-021 When x_valid=0, history, fill and z-generation SHALL hold; idle gaps of any length SHALL NOT break a partial match.
REQ-022 cfg_load=1 SHALL latch seq and seq_len and clear history and fill to 0; any x_valid bit in the same cycle SHALL be discarded, with no match possible in that cycle.
REQ-023 cfg_err SHALL be registered as 1 when the latched length is 0 or greater than MAX_LEN, and 0 otherwise; it updates in the cycle after cfg_load.
REQ-024 While cfg_err=1, z SHALL stay 0 and match_cnt SHALL hold.
REQ-025 match_cnt SHALL increment by 1 per match and saturate at all-ones without wrapping.
REQ-026 If cnt_clr and a match occur in the same cycle, match_cnt SHALL become 1; cnt_clr alone SHALL make it 0.
REQ-027 Changes on seq and seq_len SHALL have no effect except in a cfg_load cycle.

Reset
REQ-028 With rst=0 at a rising edge, the block SHALL set history=0, fill=0, latched pattern=0, latched length=0, z=0, match_cnt=0, and cfg_err=1 (unconfigured).
REQ-029 Reset SHALL take priority over cfg_load, x_valid and cnt_clr.
REQ-030 A reset asserted mid-sequence SHALL discard all partial-match state and the configuration, so a new cfg_load is needed before any match.

Verification
REQ-031 Scenario overlap: cfg_load seq=6'b101010, len=6, overlap=1, then stream 101010101010 with x_valid=1 -> z pulses one cycle after bits 6, 8, 10 and 12; match_cnt=4.
REQ-032 Scenario non-overlap: same configuration with overlap=0 and the same stream -> z pulses one cycle after bits 6 and 12 only; match_cnt=2.
REQ-033 Scenario gaps: len=3, seq=3'b110, bits 1,1,0 sent with x_valid=0 for 5 cycles between each -> a single z pulse one cycle after the third valid bit.
REQ-034 Scenario bad config: cfg_load with seq_len=0, then with seq_len=MAX_LEN+1 -> cfg_err=1 in both cases; a matching stream gives z=0 and match_cnt unchanged.
REQ-035 Scenario saturation and clear: CNT_W=2, five matches -> match_cnt=3; cnt_clr in the same cycle as a match -> match_cnt=1.
REQ-036 Scenario reset mid-match: len=6, five matching bits, rst=0 for one cycle, reconfigure, send the sixth bit -> no z; then a full 6-bit pattern -> z pulse.
